sc_eval_controller: RTL and testbench

Sequencer for one stochastic-computing evaluation. On `start` it seeds an 8-bit LFSR, presents the LFSR state and a binary probability to the SC datapath for a programmable stream length, and counts ones on the datapath's single-bit output. It returns the count as a binary result with a busy/done handshake. It sits between the host/test wrapper and the SC `circuit` datapath: it drives `input_s`/`input_b` and samples `output_circuit`.

---
 rtl/sc_ctrl_pkg.sv | 27 ++
 rtl/sc_eval_controller_if.sv | 34 +++
 rtl/sc_lfsr8.sv | 35 +++
 rtl/sc_eval_controller.sv | 132 +++++++++++++
 tb/tb_sc_eval_controller.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// sc_ctrl_pkg : shared types and constants for the SC evaluation controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sc_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // x^8+x^6+x^5+x^4+1 in right-shift form: feedback from bits 0,2,3,4
   localparam logic [7:0] LFSR_TAPS = 8'h1D;
   localparam logic [7:0] DEF_SEED  = 8'h01;
   localparam int         MAX_LEN   = 256;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {^(s & LFSR_TAPS), s[7:1]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sc_eval_controller_if.sv
//------------------------------------------------------------------------------
// sc_eval_controller_if : host handshake and SC datapath signals
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sc_eval_controller_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 9
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] prob_in;
   logic [LEN_W-1:0] len_in;
   logic [WIDTH-1:0] sc_s;
   logic [WIDTH-1:0] sc_b;
   logic             sc_bit;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] result;

   modport master (
      output start, abort, seed_in, prob_in, len_in, sc_bit,
      input  sc_s, sc_b, busy, done, result
   );

   modport slave (
      input  start, abort, seed_in, prob_in, len_in, sc_bit,
      output sc_s, sc_b, busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/sc_lfsr8.sv
//------------------------------------------------------------------------------
// sc_lfsr8 : 8-bit maximal-length LFSR with synchronous load and enable
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sc_lfsr8 #(
   parameter logic [7:0] RST_SEED = sc_ctrl_pkg::DEF_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       en,
   output logic [7:0] q
);
   import sc_ctrl_pkg::*;

   logic [7:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= RST_SEED;
      end else if (load) begin
         r_q <= seed;
      end else if (en) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sc_eval_controller.sv
//------------------------------------------------------------------------------
// sc_eval_controller : sequences one SC evaluation and counts datapath ones
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sc_eval_controller #(
   parameter int               WIDTH    = 8,
   parameter int               LEN_W    = 9,
   parameter logic [WIDTH-1:0] DEF_SEED = 8'h01
) (
   input  logic               clk,
   input  logic               rst_n,
   sc_eval_controller_if.slave bus
);
   import sc_ctrl_pkg::*;

   state_t           r_state;
   logic [WIDTH-1:0] r_seed;
   logic [WIDTH-1:0] r_prob;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_remaining;
   logic [LEN_W-1:0] r_count;
   logic [LEN_W-1:0] r_result;
   logic             r_busy;
   logic             r_done;

   logic             w_lfsr_load;
   logic             w_lfsr_en;
   logic [WIDTH-1:0] w_lfsr_q;
   logic [LEN_W-1:0] w_count_next;
   logic [LEN_W-1:0] w_len_sat;

   assign w_lfsr_load  = (r_state == ST_LOAD);
   assign w_lfsr_en    = (r_state == ST_RUN);
   assign w_count_next = r_count + {{(LEN_W-1){1'b0}}, bus.sc_bit};
   // Lengths beyond the supported maximum are clamped rather than wrapped
   assign w_len_sat    = (bus.len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len_in;

   sc_lfsr8 #(
      .RST_SEED (DEF_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (w_lfsr_load),
      .seed  (r_seed),
      .en    (w_lfsr_en),
      .q     (w_lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_seed      <= DEF_SEED;
         r_prob      <= '0;
         r_len       <= '0;
         r_remaining <= '0;
         r_count     <= '0;
         r_result    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_seed  <= (bus.seed_in == '0) ? DEF_SEED : bus.seed_in;
                  r_prob  <= bus.prob_in;
                  r_len   <= w_len_sat;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               if (bus.abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_remaining <= r_len;
                  if (r_len == '0) begin
                     r_result <= '0;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= ST_DONE;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end

            ST_RUN: begin
               // abort wins over completion in the same cycle
               if (bus.abort) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_count     <= w_count_next;
                  r_remaining <= r_remaining - LEN_W'(1);
                  if (r_remaining == LEN_W'(1)) begin
                     r_result <= w_count_next;
                     r_done   <= 1'b1;
                     r_busy   <= 1'b0;
                     r_state  <= ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.sc_s   = w_lfsr_q;
   assign bus.sc_b   = r_prob;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sc_eval_controller.sv
//------------------------------------------------------------------------------
// tb_sc_eval_controller : randomized self-checking bench with stream model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sc_eval_controller;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   last_result;
   int   mode;

   sc_eval_controller_if #(.WIDTH(8), .LEN_W(9)) bus();

   sc_eval_controller #(
      .WIDTH    (8),
      .LEN_W    (9),
      .DEF_SEED (8'h01)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-in: 0 tie-high, 1 LSB of s, 2 s<b, 3 s>b
   function automatic logic dp(input logic [7:0] s, input logic [7:0] b, input int m);
      case (m)
         0:       return 1'b1;
         1:       return s[0];
         2:       return (s < b);
         default: return (s > b);
      endcase
   endfunction

   always_comb bus.sc_bit = dp(bus.sc_s, bus.sc_b, mode);

   // Stream model: walk the polynomial sequence from the seed, summing datapath bits
   task automatic model(input logic [7:0] seed, input logic [7:0] prob, input int len,
                        output int cnt, output logic [7:0] s_end);
      logic [7:0] s;
      s   = (seed == 8'h00) ? 8'h01 : seed;
      cnt = 0;
      for (int i = 0; i < len; i++) begin
         cnt += int'(dp(s, prob, mode));
         s = {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
      end
      s_end = s;
   endtask

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // kill_k: cycle index at which abort (or reset) is raised; restart_k: stray start
   task automatic do_run(input string tag, input logic [7:0] seed, input logic [7:0] prob,
                         input int len, input int kill_k, input bit kill_rst, input int restart_k);
      int         exp_cnt, busy_n, done_n, done_k, sb_bad, res;
      logic [7:0] exp_s, s0;
      model(seed, prob, len, exp_cnt, exp_s);
      s0 = (seed == 8'h00) ? 8'h01 : seed;
      bus.start   = 1'b1;
      bus.seed_in = seed;
      bus.prob_in = prob;
      bus.len_in  = 9'(len);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.seed_in = 8'($urandom);
      bus.prob_in = 8'($urandom);
      bus.len_in  = 9'($urandom_range(0, 256));
      busy_n = 0; done_n = 0; done_k = 0; sb_bad = 0; res = -1;
      for (int k = 1; k <= len + 3; k++) begin
         if (kill_k != 0 && k == kill_k + 1) begin
            check_eq({tag, "_kill_busy"}, int'(bus.busy), 0);
            check_eq({tag, "_kill_done"}, int'(bus.done), 0);
            check_eq({tag, "_kill_result"}, int'(bus.result), kill_rst ? 0 : last_result);
            if (kill_rst) begin
               check_eq({tag, "_rst_s"}, int'(bus.sc_s), 1);
               check_eq({tag, "_rst_b"}, int'(bus.sc_b), 0);
               last_result = 0;
            end
            rst_n     = 1'b1;
            bus.abort = 1'b0;
            done_n = 0;
            repeat (3) begin
               @(negedge clk);
               done_n += int'(bus.done);
            end
            check_eq({tag, "_kill_no_done"}, done_n, 0);
            return;
         end
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_n++;
            if (done_k == 0) done_k = k;
            res = int'(bus.result);
         end
         if (k >= 2 && k <= len + 1 && bus.sc_b !== prob) sb_bad++;
         if (kill_k == 0 && k == 2 && len > 0) check_eq({tag, "_first_s"}, int'(bus.sc_s), int'(s0));
         if (kill_k == 0 && k == len + 2) check_eq({tag, "_final_s"}, int'(bus.sc_s), int'(exp_s));
         if (kill_k != 0 && k == kill_k) begin
            if (kill_rst) rst_n = 1'b0;
            else          bus.abort = 1'b1;
         end
         if (restart_k != 0 && k == restart_k) begin
            bus.start   = 1'b1;
            bus.seed_in = ~s0;
            bus.prob_in = ~prob;
            bus.len_in  = 9'(len / 2);
         end else if (restart_k != 0 && k == restart_k + 1) begin
            bus.start = 1'b0;
         end
         // A start presented during DONE must be ignored
         if (kill_k == 0 && k == len + 2) bus.start = 1'b1;
         if (k == len + 3) bus.start = 1'b0;
         @(negedge clk);
      end
      check_eq({tag, "_done_edge"}, done_k, len + 2);
      check_eq({tag, "_done_pulses"}, done_n, 1);
      check_eq({tag, "_busy_cycles"}, busy_n, len + 1);
      check_eq({tag, "_sc_b_bad"}, sb_bad, 0);
      check_eq({tag, "_result"}, res, exp_cnt);
      last_result = exp_cnt;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_errors = 0; last_result = 0; mode = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.seed_in = 8'h00; bus.prob_in = 8'h00; bus.len_in = 9'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_busy", int'(bus.busy), 0);
      check_eq("reset_done", int'(bus.done), 0);
      check_eq("reset_result", int'(bus.result), 0);
      check_eq("reset_sc_s", int'(bus.sc_s), 1);
      check_eq("reset_sc_b", int'(bus.sc_b), 0);
      rst_n = 1'b1;
      @(negedge clk);

      mode = 0; do_run("tie1_len100", 8'h5A, 8'h40, 100, 0, 1'b0, 0);
      check_eq("tie1_len100_abs", last_result, 100);
      mode = 1; do_run("lsb_len255", 8'h01, 8'h80, 255, 0, 1'b0, 0);
      check_eq("lsb_len255_abs", last_result, 128);
      check_eq("lsb_len255_wrap_s", int'(bus.sc_s), 1);
      mode = 2; do_run("seed0_len3", 8'h00, 8'hC0, 3, 0, 1'b0, 0);
      do_run("len0", 8'h33, 8'hFF, 0, 0, 1'b0, 0);
      do_run("restart", 8'h9C, 8'h70, 40, 0, 1'b0, 6);
      do_run("abort", 8'h21, 8'hA0, 30, 11, 1'b0, 0);
      do_run("midrst", 8'h77, 8'h55, 50, 8, 1'b1, 0);
      mode = 0; do_run("tie1_len256", 8'h10, 8'h01, 256, 0, 1'b0, 0);
      check_eq("tie1_len256_abs", last_result, 256);
      mode = 3; do_run("model_p0", 8'hE5, 8'h00, 200, 0, 1'b0, 0);

      for (int r = 0; r < 24; r++) begin
         int         len, kk;
         logic [7:0] sd;
         mode = $urandom_range(0, 3);
         sd   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         len  = ($urandom_range(0, 7) == 0) ? 256 : $urandom_range(0, 60);
         kk   = ($urandom_range(0, 4) == 0 && len > 2) ? $urandom_range(1, len + 1) : 0;
         do_run($sformatf("rnd%0d", r), sd, 8'($urandom), len, kk, 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
